// File: rtl/mem_sram_if.sv
// Memory-side port between the AXI4-Lite bridge (M) and its backing store (S).
// One write channel and one pipelined read channel, no backpressure.
interface mem_if #(
  parameter int unsigned ALEN = 8,
  parameter int unsigned DLEN = 32
) ();

  logic            wen;
  logic [ALEN-1:0] waddr;
  logic [DLEN-1:0] wdata;
  logic            ren;
  logic [ALEN-1:0] raddr;
  logic            rvalid;
  logic [DLEN-1:0] rdata;

  modport M (
    output wen, waddr, wdata, ren, raddr,
    input  rvalid, rdata
  );

  modport S (
    input  wen, waddr, wdata, ren, raddr,
    output rvalid, rdata
  );

endinterface

// File: rtl/mem_sram.sv
// Dual-port SRAM model behind the bridge: one write and one read per cycle, fixed-latency reads.
// Define MEM_SRAM_FWD_EN for write-first forwarding on same-cycle same-address read/write.
module mem_sram #(
  parameter int unsigned ALEN   = 8,
  parameter int unsigned DLEN   = 32,
  parameter int unsigned DEPTH  = 2 ** ALEN,
  parameter int unsigned RD_LAT = 1
) (
  input  logic       clk,
  input  logic       rstn,
  mem_if.S           mem,
  output logic [7:0] oob_cnt
);

  if ((RD_LAT < 1) || (RD_LAT > 4)) begin : g_bad_rd_lat
    $error("mem_sram: RD_LAT must be in 1..4");
  end
  if ((DLEN % 8) != 0) begin : g_bad_dlen
    $error("mem_sram: DLEN must be a multiple of 8");
  end
  if ((DEPTH < 1) || (DEPTH > 2 ** ALEN)) begin : g_bad_depth
    $error("mem_sram: DEPTH must be in 1..2**ALEN");
  end

  localparam int unsigned   IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ALEN:0] DEPTH_W = (ALEN + 1)'(DEPTH);

  logic [DLEN-1:0]  array_q [DEPTH];
  logic [RD_LAT-1:0] valid_q;
  logic [DLEN-1:0]  data_q  [RD_LAT];
  logic [7:0]       oob_q;
  logic [7:0]       oob_d;

  logic             wr_in_range;
  logic             rd_in_range;
  logic             wr_hit;
  logic             rd_hit;
  logic             wr_oob;
  logic             rd_oob;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic [DLEN-1:0]  rd_word;
  logic [1:0]       oob_inc;
  logic [8:0]       oob_sum;

  assign wr_in_range = ({1'b0, mem.waddr} < DEPTH_W);
  assign rd_in_range = ({1'b0, mem.raddr} < DEPTH_W);
  assign wr_hit      = mem.wen && wr_in_range;
  assign rd_hit      = mem.ren && rd_in_range;
  assign wr_oob      = mem.wen && !wr_in_range;
  assign rd_oob      = mem.ren && !rd_in_range;
  assign wr_idx      = mem.waddr[IDX_W-1:0];
  assign rd_idx      = mem.raddr[IDX_W-1:0];

  // Contents are deliberately not reset; only the write itself is gated by rstn.
  always_ff @(posedge clk) begin
    if (rstn && wr_hit) begin
      array_q[wr_idx] <= mem.wdata;
    end
  end

  // Sampled in the request cycle, so later writes cannot disturb a read in flight.
  always_comb begin
    rd_word = '0;
    if (rd_hit) begin
      rd_word = array_q[rd_idx];
`ifdef MEM_SRAM_FWD_EN
      if (wr_hit && (mem.waddr == mem.raddr)) begin
        rd_word = mem.wdata;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        valid_q[i] <= 1'b0;
        data_q[i]  <= '0;
      end
    end else begin
      valid_q[0] <= mem.ren;
      data_q[0]  <= rd_word;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign mem.rvalid = valid_q[RD_LAT-1];
  assign mem.rdata  = valid_q[RD_LAT-1] ? data_q[RD_LAT-1] : '0;

  // A read and a write can both miss in one cycle, so the step is 0..2 before saturation.
  always_comb begin
    oob_inc = 2'(wr_oob) + 2'(rd_oob);
    oob_sum = {1'b0, oob_q} + {7'b0, oob_inc};
    oob_d   = oob_sum[8] ? 8'hff : oob_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      oob_q <= 8'h00;
    end else begin
      oob_q <= oob_d;
    end
  end

  assign oob_cnt = oob_q;

endmodule

// File: doc/mem_sram.md
# mem_sram

Synchronous dual-port SRAM model that terminates the `mem_if` master port of the AXI4-Lite-to-memory bridge. It accepts single-cycle write strobes and pipelined read requests, and returns read data through a fixed-latency valid pipeline. It serves as the backing store behind the bridge in both simulation and FPGA builds.

## Interface
Parameters:
- `ALEN`, 8: address width in bits; must equal `mem.ALEN`.
- `DLEN`, 32: data width in bits; must equal `mem.DLEN`; must be a multiple of 8.
- `DEPTH`, 2**ALEN: number of words; 1 ≤ DEPTH ≤ 2**ALEN.
- `RD_LAT`, 1: read latency in cycles; legal range 1..4, checked by an elaboration-time assertion.

Ports (reset rstn, synchronous, active-low; clock clk):
- `clk`  in  1  clock; all logic is on the rising edge.
- `rstn`  in  1  synchronous active-low reset.
- `mem`  mem_if.S  —  slave side of `mem_if`. Signals:
  - `mem.wen`  in  1  write strobe.
  - `mem.waddr`  in  ALEN  write word address.
  - `mem.wdata`  in  DLEN  write data.
  - `mem.ren`  in  1  read request.
  - `mem.raddr`  in  ALEN  read word address.
  - `mem.rvalid`  out  1  read data valid.
  - `mem.rdata`  out  DLEN  read data.
- `oob_cnt`  out  8  count of out-of-range accesses; saturates at 255.

## Operation
- Storage: an array of `DEPTH` × `DLEN`. Reset does not clear the array; its contents survive `rstn`.
- Write: when `wen`=1 and `waddr` < DEPTH, `array[waddr]` takes `wdata` at the clock edge. When `waddr` ≥ DEPTH, the write is dropped and `oob_cnt` increments.
- Read: when `ren`=1, the array is sampled at `raddr` in that cycle. The request then enters a pipeline that is `RD_LAT` stages deep, each stage holding a valid bit and data.
  - A read with `raddr` ≥ DEPTH returns 0 with `rvalid`=1 and increments `oob_cnt`.
- Accepting requests: there is no backpressure. One read and one write can be accepted every cycle, continuously.
- Counting: if a read and a write are both out of range in the same cycle, `oob_cnt` increments by 2, saturating at 255.
- Read data snapshot: data is captured in the request cycle. Writes to the same address in later cycles do not alter a read already in flight.
- Same-cycle read and write to the same in-range address: the result depends on `MEM_SRAM_FWD_EN` (see Configuration).
- `rdata` is driven to 0 whenever `rvalid`=0.

## Timing
- Reset values: `rvalid`=0, `rdata`=0, `oob_cnt`=0, and every pipeline valid bit is 0.
- Read latency: `ren` high in cycle N gives `rvalid`=1 with data in cycle N+RD_LAT, for exactly one cycle per request.
- Throughput: back-to-back reads in cycles N..N+k produce `rvalid` in cycles N+RD_LAT..N+RD_LAT+k, in order.
- Write timing: a write in cycle N is visible to reads issued in cycle N+1 or later.
- Reset mid-operation: `rstn` low flushes all in-flight reads; no `rvalid` is produced for them. Inputs are ignored while `rstn`=0.
- The first request is accepted in the first cycle with `rstn`=1.

## Configuration
- Macro: `MEM_SRAM_FWD_EN`.
- Defined: a same-cycle read and write to the same in-range address returns the new `wdata` (write-first forwarding).
- Undefined: the same case returns the array contents from before the write (read-first).
- Both settings leave latency and all other behaviour unchanged.

## Test plan
- Basic access, RD_LAT=1: write 0xDEADBEEF to address 0x10, then read 0x10 in the next cycle. Required: `rvalid`=1 one cycle after `ren`, `rdata`=0xDEADBEEF.
- Streaming reads, RD_LAT=3: addresses 0..3 are preloaded with 0x0, 0x11, 0x22, 0x33; issue four back-to-back reads of 0..3. Required: `rvalid` high for 4 consecutive cycles starting 3 cycles after the first `ren`, with data in order 0x0, 0x11, 0x22, 0x33.
- Same-cycle collision: address 5 holds 0xAAAA0000; in one cycle, write 0x12345678 to address 5 and read address 5. Required: 0x12345678 with `MEM_SRAM_FWD_EN` defined, 0xAAAA0000 without it. A follow-up read returns 0x12345678 in both builds.
- Out of range, DEPTH=16, ALEN=8: write to address 0x20, then read address 0x20. Required: the write is dropped, the read returns 0 with `rvalid`=1, and `oob_cnt`=2. After 300 further out-of-range reads, `oob_cnt`=255.
- Reset mid-flight, RD_LAT=4: issue 2 reads, then assert `rstn` low 2 cycles later for 1 cycle. Required: no `rvalid` for the flushed reads, and `oob_cnt`=0. Array data written before the reset reads back unchanged afterwards.
- Snapshot rule, RD_LAT=2: read address 7 (holding 0x1) in cycle N, then write 0x2 to address 7 in cycle N+1. Required: `rdata`=0x1 in cycle N+2.
